// File: rtl/buffer_scheduler.sv
// -----------------------------------------------------------------------------
// buffer_scheduler
//
// Shares a small 3-entry data buffer between two write requesters (A, B) and
// one read requester. Issues single-cycle buf_wr / buf_rd strobes, never both
// at once, never a write into a full buffer, never a read from an empty one.
// Read data is registered and returned with a one-cycle rd_valid pulse.
//
// Every operation ends with a SETTLE cycle so the buffer's full/empty flags
// reflect the completed op before the next decision is taken in IDLE.
//
// Ports:
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   req_a/data_a/ack_a  writer A: level request, data, one-cycle grant pulse
//   req_b/data_b/ack_b  writer B: same handshake as A
//   rd_req/rd_ack       reader: level request, one-cycle strobe-issued pulse
//   rd_valid/rd_dout    read data return: pulse and held data word
//   buf_wr/buf_w_data   write strobe and data towards the buffer
//   buf_rd/buf_r_data   read strobe towards and data from the buffer
//   buf_full/buf_empty  buffer status flags
// -----------------------------------------------------------------------------
module buffer_scheduler #(
  parameter int DBIT = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_a,
  input  logic [DBIT-1:0] data_a,
  output logic            ack_a,
  input  logic            req_b,
  input  logic [DBIT-1:0] data_b,
  output logic            ack_b,
  input  logic            rd_req,
  output logic            rd_ack,
  output logic            rd_valid,
  output logic [DBIT-1:0] rd_dout,
  output logic            buf_wr,
  output logic [DBIT-1:0] buf_w_data,
  output logic            buf_rd,
  input  logic [DBIT-1:0] buf_r_data,
  input  logic            buf_full,
  input  logic            buf_empty
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    SETTLE
  } state_t;

  state_t state, state_nxt;

  // op_last_wr: 1 when the most recent operation was a write.
  // wr_last_b:  1 when the most recent write grant went to B.
  logic op_last_wr, op_last_wr_nxt;
  logic wr_last_b,  wr_last_b_nxt;

  logic            ack_a_nxt, ack_b_nxt, rd_ack_nxt, rd_valid_nxt;
  logic            buf_wr_nxt, buf_rd_nxt;
  logic [DBIT-1:0] buf_w_data_nxt, rd_dout_nxt;

  logic e_a, e_b, e_r;
  logic do_write, do_read, grant_a;

  assign e_a = req_a & ~buf_full;
  assign e_b = req_b & ~buf_full;
  assign e_r = rd_req & ~buf_empty;

  // On a read/write conflict the op type opposite to the last one wins;
  // otherwise whatever is eligible goes. Between writers, the one that was
  // not granted last wins a tie.
  assign do_write = (e_a | e_b) & (~e_r | ~op_last_wr);
  assign do_read  = e_r & ~do_write;
  assign grant_a  = e_a & (~e_b | wr_last_b);

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered, so each strobe/ack is high exactly in its own state.
  always_comb begin
    state_nxt      = state;
    op_last_wr_nxt = op_last_wr;
    wr_last_b_nxt  = wr_last_b;
    ack_a_nxt      = 1'b0;
    ack_b_nxt      = 1'b0;
    rd_ack_nxt     = 1'b0;
    rd_valid_nxt   = 1'b0;
    buf_wr_nxt     = 1'b0;
    buf_rd_nxt     = 1'b0;
    buf_w_data_nxt = buf_w_data;
    rd_dout_nxt    = rd_dout;

    case (state)
      IDLE: begin
        if (do_write) begin
          state_nxt      = WR;
          buf_wr_nxt     = 1'b1;
          op_last_wr_nxt = 1'b1;
          if (grant_a) begin
            ack_a_nxt      = 1'b1;
            buf_w_data_nxt = data_a;
            wr_last_b_nxt  = 1'b0;
          end else begin
            ack_b_nxt      = 1'b1;
            buf_w_data_nxt = data_b;
            wr_last_b_nxt  = 1'b1;
          end
        end else if (do_read) begin
          state_nxt      = RD;
          buf_rd_nxt     = 1'b1;
          rd_ack_nxt     = 1'b1;
          op_last_wr_nxt = 1'b0;
        end
      end
      WR:  state_nxt = SETTLE;
      RD:  state_nxt = CAP;
      // The buffer updated buf_r_data at the edge that sampled buf_rd, so it
      // is stable throughout CAP and is captured at the end of it.
      CAP: begin
        state_nxt    = SETTLE;
        rd_valid_nxt = 1'b1;
        rd_dout_nxt  = buf_r_data;
      end
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers. Reset starts with op_last = read and
  // wr_last = B so that writes, and writer A, win the first conflicts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_last_wr <= 1'b0;
      wr_last_b  <= 1'b1;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      buf_wr     <= 1'b0;
      buf_rd     <= 1'b0;
      buf_w_data <= '0;
      rd_dout    <= '0;
    end else begin
      state      <= state_nxt;
      op_last_wr <= op_last_wr_nxt;
      wr_last_b  <= wr_last_b_nxt;
      ack_a      <= ack_a_nxt;
      ack_b      <= ack_b_nxt;
      rd_ack     <= rd_ack_nxt;
      rd_valid   <= rd_valid_nxt;
      buf_wr     <= buf_wr_nxt;
      buf_rd     <= buf_rd_nxt;
      buf_w_data <= buf_w_data_nxt;
      rd_dout    <= rd_dout_nxt;
    end
  end

endmodule

// File: tb/tb_buffer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_buffer_scheduler
//
// Directed bench for buffer_scheduler. A small behavioural model of the
// 3-entry buffer (last-written word is read first) drives full/empty and
// read data. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_buffer_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, rd_req = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       ack_a, ack_b, rd_ack, rd_valid;
  logic [7:0] rd_dout;
  logic       buf_wr, buf_rd;
  logic [7:0] buf_w_data;
  logic [7:0] buf_r_data = '0;
  logic       buf_full, buf_empty;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  buffer_scheduler #(.DBIT(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_a      (req_a),
    .data_a     (data_a),
    .ack_a      (ack_a),
    .req_b      (req_b),
    .data_b     (data_b),
    .ack_b      (ack_b),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_dout    (rd_dout),
    .buf_wr     (buf_wr),
    .buf_w_data (buf_w_data),
    .buf_rd     (buf_rd),
    .buf_r_data (buf_r_data),
    .buf_full   (buf_full),
    .buf_empty  (buf_empty)
  );

  // Buffer model: stack of 3 entries. sink_mode accepts writes without
  // storing them, so a writer test can run without ever filling up.
  logic [7:0] mem [0:2];
  logic [1:0] cnt = 2'd0;
  logic       sink_mode = 1'b0;
  logic       clr_req = 1'b0;
  logic [1:0] preload_cnt = 2'd0;
  logic [7:0] preload_val = '0;
  int         both_high_cnt = 0;
  int         misuse_cnt = 0;

  assign buf_full  = (cnt == 2'd3);
  assign buf_empty = (cnt == 2'd0);

  always @(posedge clk) begin
    if (buf_wr === 1'b1 && buf_rd === 1'b1) both_high_cnt <= both_high_cnt + 1;
    if (clr_req) begin
      cnt    <= preload_cnt;
      mem[0] <= preload_val;
    end else if (buf_wr === 1'b1) begin
      if (cnt == 2'd3) misuse_cnt <= misuse_cnt + 1;
      else if (!sink_mode) begin
        mem[cnt] <= buf_w_data;
        cnt      <= cnt + 2'd1;
      end
    end else if (buf_rd === 1'b1) begin
      if (cnt == 2'd0) misuse_cnt <= misuse_cnt + 1;
      else begin
        buf_r_data <= mem[cnt - 2'd1];
        cnt        <= cnt - 2'd1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_buffer(input logic [1:0] n, input logic [7:0] v);
    preload_cnt = n;
    preload_val = v;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Waits up to 12 cycles for a pulse: 0 = ack_a, 1 = rd_ack, 2 = rd_valid.
  task automatic wait_for(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if ((which == 0 && ack_a === 1'b1) || (which == 1 && rd_ack === 1'b1) ||
          (which == 2 && rd_valid === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_a = 1'b1; req_b = 1'b1; rd_req = 1'b1;
    data_a = 8'hFF; data_b = 8'hEE;
    repeat (3) tick();
    checks++; if (ack_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack_a got=%b exp=0", ack_a); end
    checks++; if (ack_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack_b got=%b exp=0", ack_b); end
    checks++; if (rd_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_ack got=%b exp=0", rd_ack); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (buf_wr !== 1'b0) begin failures++; $display("[TB] FAIL reset_buf_wr got=%b exp=0", buf_wr); end
    checks++; if (buf_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_buf_rd got=%b exp=0", buf_rd); end
    checks++; if (rd_dout !== 8'h00) begin failures++; $display("[TB] FAIL reset_rd_dout got=%h exp=00", rd_dout); end
    checks++; if (buf_w_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_buf_w_data got=%h exp=00", buf_w_data); end
    req_a = 1'b0; req_b = 1'b0; rd_req = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    data_a = 8'h3C;
    req_a = 1'b1;
    tick();
    checks++; if (buf_wr !== 1'b1) begin failures++; $display("[TB] FAIL single_buf_wr got=%b exp=1", buf_wr); end
    checks++; if (ack_a !== 1'b1) begin failures++; $display("[TB] FAIL single_ack_a got=%b exp=1", ack_a); end
    checks++; if (buf_w_data !== 8'h3C) begin failures++; $display("[TB] FAIL single_w_data got=%h exp=3c", buf_w_data); end
    checks++; if (ack_b !== 1'b0 || buf_rd !== 1'b0) begin failures++; $display("[TB] FAIL single_other_strobes got=%b%b exp=00", ack_b, buf_rd); end
    req_a = 1'b0;
    data_b = 8'h44;
    req_b = 1'b1;
    tick();
    checks++; if ({buf_wr, ack_a} !== 2'b00) begin failures++; $display("[TB] FAIL single_one_cycle got=%b exp=00", {buf_wr, ack_a}); end
    checks++; if (buf_w_data !== 8'h3C) begin failures++; $display("[TB] FAIL single_w_data_hold got=%h exp=3c", buf_w_data); end
    tick();
    checks++; if (ack_b !== 1'b0) begin failures++; $display("[TB] FAIL single_settle_early got=%b exp=0", ack_b); end
    tick();
    checks++; if (ack_b !== 1'b1) begin failures++; $display("[TB] FAIL single_idle_at_t3 got=%b exp=1", ack_b); end
    req_b = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_alternate_writers();
    logic [3:0] order;
    int         n;
    pulse_reset();
    clear_buffer(2'd0, 8'h00);
    sink_mode = 1'b1;
    data_a = 8'hA1; data_b = 8'hB2;
    req_a = 1'b1; req_b = 1'b1;
    order = '0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack_a === 1'b1 || ack_b === 1'b1) begin
        order = {order[2:0], ack_a};
        n++;
        checks++;
        if (buf_w_data !== (ack_a === 1'b1 ? 8'hA1 : 8'hB2)) begin
          failures++; $display("[TB] FAIL alt_w_data got=%h ack_a=%b ack_b=%b", buf_w_data, ack_a, ack_b);
        end
      end
    end
    checks++; if (n != 4) begin failures++; $display("[TB] FAIL alt_grant_count got=%0d exp=4", n); end
    checks++; if (order !== 4'b1010) begin failures++; $display("[TB] FAIL alt_order got=%b exp=1010", order); end
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) tick();
    sink_mode = 1'b0;
  endtask

  task automatic test_rw_alternate();
    logic [3:0] order;
    int         n, nv;
    pulse_reset();
    clear_buffer(2'd1, 8'h77);
    data_a = 8'h10;
    req_a = 1'b1; rd_req = 1'b1;
    order = '0;
    n = 0; nv = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (buf_wr === 1'b1 || buf_rd === 1'b1) begin
        order = {order[2:0], buf_wr};
        n++;
      end
      if (rd_valid === 1'b1) begin
        nv++;
        checks++;
        if (rd_dout !== 8'h10) begin failures++; $display("[TB] FAIL rw_rd_dout got=%h exp=10", rd_dout); end
      end
    end
    req_a = 1'b0; rd_req = 1'b0;
    checks++; if (n != 4) begin failures++; $display("[TB] FAIL rw_op_count got=%0d exp=4", n); end
    checks++; if (order !== 4'b1010) begin failures++; $display("[TB] FAIL rw_order got=%b exp=1010", order); end
    checks++; if (nv != 2) begin failures++; $display("[TB] FAIL rw_valid_count got=%0d exp=2", nv); end
    repeat (2) tick();
  endtask

  task automatic test_full();
    logic [7:0] wvals [0:2];
    bit         ok;
    int         nb;
    wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33;
    clear_buffer(2'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      data_a = wvals[k];
      req_a = 1'b1;
      wait_for(0, ok);
      req_a = 1'b0;
      checks++; if (!ok) begin failures++; $display("[TB] FAIL full_fill_ack got=timeout exp=ack_a word=%h", wvals[k]); end
      repeat (2) tick();
    end
    data_b = 8'h44;
    req_b = 1'b1;
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack_b === 1'b1 || buf_wr === 1'b1) nb++;
    end
    checks++; if (nb != 0) begin failures++; $display("[TB] FAIL full_no_ack_b got=%0d exp=0", nb); end
    rd_req = 1'b1;
    tick();
    checks++; if ({rd_ack, buf_rd} !== 2'b11) begin failures++; $display("[TB] FAIL full_read_issue got=%b exp=11", {rd_ack, buf_rd}); end
    checks++; if (ack_b !== 1'b0) begin failures++; $display("[TB] FAIL full_ack_b_during_rd got=%b exp=0", ack_b); end
    rd_req = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_valid_early got=%b exp=0", rd_valid); end
    tick();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_valid_t3 got=%b exp=1", rd_valid); end
    checks++; if (rd_dout !== 8'h33) begin failures++; $display("[TB] FAIL full_rd_dout got=%h exp=33", rd_dout); end
    tick();
    checks++; if ({rd_valid, ack_b} !== 2'b00) begin failures++; $display("[TB] FAIL full_idle_cycle got=%b exp=00", {rd_valid, ack_b}); end
    tick();
    checks++; if (ack_b !== 1'b1) begin failures++; $display("[TB] FAIL full_ack_b_after got=%b exp=1", ack_b); end
    checks++; if (buf_w_data !== 8'h44) begin failures++; $display("[TB] FAIL full_b_data got=%h exp=44", buf_w_data); end
    req_b = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_empty_wait();
    bit ok;
    int nr;
    clear_buffer(2'd0, 8'h00);
    rd_req = 1'b1;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (buf_rd === 1'b1 || rd_ack === 1'b1) nr++;
    end
    checks++; if (nr != 0) begin failures++; $display("[TB] FAIL empty_no_read got=%0d exp=0", nr); end
    data_a = 8'h5A;
    req_a = 1'b1;
    wait_for(0, ok);
    req_a = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL empty_write_ack got=timeout exp=ack_a"); end
    wait_for(1, ok);
    rd_req = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL empty_read_ack got=timeout exp=rd_ack"); end
    wait_for(2, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL empty_rd_valid got=timeout exp=rd_valid"); end
    checks++; if (rd_dout !== 8'h5A) begin failures++; $display("[TB] FAIL empty_rd_dout got=%h exp=5a", rd_dout); end
    tick();
  endtask

  task automatic test_reset_in_cap();
    clear_buffer(2'd1, 8'h99);
    rd_req = 1'b1;
    tick();
    checks++; if (rd_ack !== 1'b1) begin failures++; $display("[TB] FAIL cap_rd_ack got=%b exp=1", rd_ack); end
    rd_req = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL cap_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_dout !== 8'h00) begin failures++; $display("[TB] FAIL cap_rd_dout got=%h exp=00", rd_dout); end
    checks++; if ({ack_a, ack_b, rd_ack, buf_wr, buf_rd} !== 5'b0) begin failures++; $display("[TB] FAIL cap_outputs got=%b exp=00000", {ack_a, ack_b, rd_ack, buf_wr, buf_rd}); end
    checks++; if (buf_w_data !== 8'h00) begin failures++; $display("[TB] FAIL cap_w_data got=%h exp=00", buf_w_data); end
    reset_n = 1'b1;
    data_a = 8'hA1; data_b = 8'hB2;
    req_a = 1'b1; req_b = 1'b1;
    tick();
    checks++; if ({ack_a, ack_b} !== 2'b10) begin failures++; $display("[TB] FAIL cap_conflict_grant got=%b exp=10", {ack_a, ack_b}); end
    checks++; if (buf_w_data !== 8'hA1) begin failures++; $display("[TB] FAIL cap_conflict_data got=%h exp=a1", buf_w_data); end
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_alternate_writers();
    test_rw_alternate();
    test_full();
    test_empty_wait();
    test_reset_in_cap();
    checks++; if (both_high_cnt != 0) begin failures++; $display("[TB] FAIL both_strobes got=%0d exp=0", both_high_cnt); end
    checks++; if (misuse_cnt != 0) begin failures++; $display("[TB] FAIL buffer_misuse got=%0d exp=0", misuse_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/buffer_scheduler.md
# buffer_scheduler

Scheduler sitting between the 3-entry data buffer (`wr`/`rd`/`full`/`empty` interface) and its users. It shares the buffer between two write requesters (A, B) and one read requester, and issues single-cycle `wr`/`rd` strobes. It never strobes both in the same cycle, never writes when full and never reads when empty. It also registers the read data and returns it with a valid pulse.

## Interface
Parameters:
- `DBIT`, 8, data width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `req_a`  in  1  write request from A, level, held until `ack_a`
- `data_a`  in  DBIT  write data from A, stable while `req_a`=1
- `ack_a`  out  1  one-cycle pulse, A's data is being written this cycle
- `req_b`  in  1  write request from B, same rules as A
- `data_b`  in  DBIT  write data from B
- `ack_b`  out  1  one-cycle pulse for B
- `rd_req`  in  1  read request, level, held until `rd_ack`
- `rd_ack`  out  1  one-cycle pulse, read strobe issued this cycle
- `rd_valid`  out  1  one-cycle pulse, `rd_dout` holds the read word
- `rd_dout`  out  DBIT  last word read; held until the next read
- `buf_wr`  out  1  write strobe to buffer
- `buf_w_data`  out  DBIT  write data to buffer
- `buf_rd`  out  1  read strobe to buffer
- `buf_r_data`  in  DBIT  buffer read data, updated at the edge that samples `buf_rd`
- `buf_full`  in  1  buffer full flag
- `buf_empty`  in  1  buffer empty flag

## Operation
- FSM states: IDLE, WR, RD, CAP, SETTLE. All outputs are registered.
- Eligibility is evaluated only in IDLE:
  - `eA = req_a & !buf_full`
  - `eB = req_b & !buf_full`
  - `eR = rd_req & !buf_empty`
- Read/write choice: if `eR` and (`eA`|`eB`), take the op type opposite to `op_last`. Otherwise take whichever is eligible. If nothing is eligible, stay in IDLE.
- Writer choice: if both `eA` and `eB`, grant the writer other than `wr_last`. Otherwise grant the single eligible writer.
- IDLE → WR on a write grant.
  - In WR: `buf_wr`=1, `buf_w_data` = granted writer's data (latched in IDLE), and the matching `ack_x`=1.
  - Update `wr_last` and set `op_last`=write.
  - WR → SETTLE.
- IDLE → RD on a read grant.
  - In RD: `buf_rd`=1, `rd_ack`=1, set `op_last`=read.
  - RD → CAP.
  - In CAP: `rd_dout` <= `buf_r_data` at the end of CAP; `rd_valid`=1 in the following cycle.
  - CAP → SETTLE.
- SETTLE → IDLE unconditionally. This cycle lets the buffer's `full`/`empty` flags reflect the completed op.
- `buf_w_data` holds its last value outside WR. All strobes and acks are 0 outside their own state.
- A requester that drops its request before its ack is simply not granted. No error is flagged.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - Next state is IDLE.
  - `ack_a`, `ack_b`, `rd_ack`, `rd_valid`, `buf_wr`, `buf_rd` all go to 0.
  - `rd_dout`=0 and `buf_w_data`=0.
  - `op_last`=read, so writes win the first conflict.
  - `wr_last`=B, so A wins the first conflict.
- Write latency: request seen in IDLE at cycle T → `buf_wr`/`ack` during T+1 → IDLE again at T+3. Throughput is 1 op per 3 cycles.
- Read latency: request seen at T → `buf_rd`/`rd_ack` at T+1 → CAP at T+2 → `rd_valid` with data at T+3 (SETTLE) → IDLE at T+4.
- `buf_wr` and `buf_rd` are never high in the same cycle.
- Full buffer: writers are held off; a pending read is still served and frees a slot.
- Empty buffer: `rd_req` waits; writes proceed.
- Reset mid-operation:
  - A strobe already high during the reset cycle is still sampled by the buffer at that edge; its ack has already been given.
  - A read in CAP loses its `rd_valid` and `rd_dout` update.
  - Buffer contents are not cleared by this block.

## Test plan
- Reset, then `req_a`=1 with `data_a`=0x3C, buffer empty → `buf_wr`=1, `buf_w_data`=0x3C and `ack_a`=1 exactly one cycle, 1 cycle after the request; FSM back in IDLE 3 cycles after the request.
- `req_a` and `req_b` high together, continuously, buffer never full → grants alternate A, B, A, B; first grant goes to A after reset.
- Buffer holds 1 entry, `req_a`=1 and `rd_req`=1 held → write first, then read, alternating; `buf_wr` and `buf_rd` are never both high.
- Write 0x11, 0x22, 0x33 until `buf_full`=1, then assert `req_b`:
  - no `ack_b` while full;
  - issue `rd_req` → `rd_valid` with `rd_dout`=0x33 at T+3;
  - then `ack_b` follows.
- `rd_req`=1 with buffer empty for 10 cycles → no `buf_rd`/`rd_ack`; then write 0x5A → read issued, `rd_dout`=0x5A.
- `reset_n`=0 during CAP → no `rd_valid`; all outputs 0 next cycle; FSM in IDLE; the next conflict grants A.
